pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel, fixed-width PWM.
- Generates NCH independent PWM outputs from one shared counter with programmable period and prescaler.
- Per-channel duty is written through a valid/ready port into shadow registers. Shadow values take effect only at the period boundary, so outputs never glitch mid-period.
- Sits between the switch/register front-end and the LED/motor drivers.

Parameters:
- NCH, 4, number of PWM channels (1..16)
- CW, 8, counter/period/duty width in bits
- PSW, 8, prescaler width in bits

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- en  input  1  run enable; when 0, counter frozen at 0
- prescale  input  PSW  counter advances every prescale+1 clk cycles
- period  input  CW  counter counts 0..period inclusive
- upd_valid  input  1  duty update request
- upd_ready  output  1  update accepted when upd_valid && upd_ready
- upd_ch  input  $clog2(NCH) (min 1)  target channel
- upd_duty  input  CW  new duty value (high-time in ticks)
- pwm_out  output  NCH  registered PWM outputs
- period_strobe  output  1  one-cycle pulse on counter wrap
- cnt  output  CW  current counter value

Behaviour:
- Reset values: cnt=0, prescaler=0, duty_act[*]=0, duty_shd[*]=0, pend[*]=0, pwm_out=0, period_strobe=0, upd_ready=1.
- Prescaler: ps counts 0..prescale. tick=1 when en && ps==prescale, and ps then returns to 0. prescale=0 gives tick every cycle.
- Counter: on tick, if cnt>=period then cnt<=0 (wrap), else cnt<=cnt+1.
  - Period is sampled live. Lowering period below cnt forces a wrap on the next tick.
  - period=0 gives a wrap every tick.
- period_strobe: registered, high for exactly one clk in the cycle after a wrap.
- Update port:
  - upd_ready = !pend[upd_ch] (combinational on upd_ch).
  - On accept: duty_shd[upd_ch]<=upd_duty and pend[upd_ch]<=1.
  - upd_ch >= NCH: accepted and dropped (no state change).
- Apply: on wrap, for every channel with pend set, duty_act<=duty_shd and pend cleared.
  - An accept in the same cycle as a wrap goes to shadow and applies at the following wrap.
  - While en=0, pending shadows apply on the next clk (no wrap needed).
- Compare: pwm_out[i]<=en && (cnt < duty_act[i]), one clk after cnt.
  - duty=0 gives constant 0.
  - duty>period gives constant 1 while en.
  - Full-width unsigned compare, no truncation.
- Required invariant: duty_act[a] <= duty_act[b] implies pwm_out[a] -> pwm_out[b] every cycle.
- en deassert: the next clk clears cnt, ps and pwm_out. Shadows and duty_act are retained.
- rst mid-period: all state returns to reset values on the next clk. Pending updates are discarded.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- Defined:
  - Counter runs up 0..period, then down period..0. The direction register flips at each end, and the endpoint values are not repeated.
  - Wrap (apply point and period_strobe) occurs only when the counter reaches 0 on the down-count.
  - Output is still cnt < duty_act, so each pulse is centred on cnt=0.
  - Full cycle is 2*period ticks; period=0 degenerates to edge-aligned behaviour.
- Not defined: edge-aligned sawtooth as above, and no direction register is synthesised.

Decomposition:
- Package pwm_pkg holds:
  - default NCH/CW/PSW localparams
  - typedefs duty_t (logic [CW-1:0]) and ch_idx_t
  - a function for the channel-index width with a minimum of 1
- Sub-module pwm_channel, instantiated NCH times in a generate loop. It holds shadow, pend flag, active duty and the compare/output flop. Inputs: clk, rst, en, cnt, wrap, wr_en, wr_duty.
- Prescaler and counter stay in the top level.

Test Plan:
- Reset then prescale=0, period=9, duties {0,3,5,12}, en=1:
  - ch0 constant 0, ch1 high 3 of 10 cycles, ch2 high 5 of 10, ch3 constant 1.
  - period_strobe every 10 cycles.
- prescale=3, period=4, duty=2: counter advances every 4 clk, pulse is 8 clk high per 20 clk.
- Write ch1=7 mid-period (cnt=4, period=9):
  - old duty persists until wrap, then new duty applies.
  - upd_ready for ch1 low from accept until the clk after the wrap.
  - A second write to ch1 stalls, while a write to ch2 is accepted.
- Reduce period from 15 to 5 while cnt=10: wrap on the next tick, cnt=0, one period_strobe.
- Assert rst while cnt=7 and a pending update exists: next clk all outputs 0, upd_ready=1, and the pending duty is never applied.
- With PWM_CENTER_ALIGN_EN, period=4, duty=2:
  - cnt sequence 0,1,2,3,4,3,2,1,0 repeating.
  - Output high at cnt 0,1, i.e. 3 of 8 cycles.
  - Strobe only after reaching 0 on the down-count.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and helper types for the multi-channel PWM.
// The channel-index width never drops below one bit, so a single-channel
// build still has a legal upd_ch port.
package pwm_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;
    localparam int PSW_DEF = 8;

    // Channel-index width, at least 1 bit
    function automatic int ch_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHW_DEF = ch_idx_width(NCH_DEF);

    typedef logic [CW_DEF-1:0]  duty_t;
    typedef logic [CHW_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow register, pending flag, active duty and the
// registered compare output. A written duty waits in the shadow until the
// counter wraps, or is taken on the next clk while the counter is stopped.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] cnt,
    input  logic          wrap,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_duty,
    output logic          pend,
    output logic          pwm
);

    logic [CW-1:0] duty_shd_reg;
    logic [CW-1:0] duty_act_reg;
    logic          pend_reg;
    logic          pwm_reg;
    logic          apply;

    // Apply the shadow at a period boundary, or immediately while stopped
    assign apply = pend_reg && (wrap || !en);

    // Shadow/active duty bookkeeping and the registered compare
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_shd_reg <= '0;
            duty_act_reg <= '0;
            pend_reg     <= 1'b0;
            pwm_reg      <= 1'b0;
        end else begin
            if (apply) begin
                duty_act_reg <= duty_shd_reg;
            end
            // A write only arrives while pend is clear, so it cannot
            // collide with an apply of the same channel.
            if (wr_en) begin
                duty_shd_reg <= wr_duty;
                pend_reg     <= 1'b1;
            end else if (apply) begin
                pend_reg     <= 1'b0;
            end
            pwm_reg <= en && (cnt < duty_act_reg);
        end
    end

    assign pend = pend_reg;
    assign pwm  = pwm_reg;

endmodule

// File: rtl/pwm_multi_channel.sv
// NCH-channel PWM sharing one prescaler and one period counter.
// Optional build macro: PWM_CENTER_ALIGN_EN selects an up/down (centre-
// aligned) counter; without it the counter is an edge-aligned sawtooth.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter  int NCH = NCH_DEF,
    parameter  int CW  = CW_DEF,
    parameter  int PSW = PSW_DEF,
    localparam int CHW = ch_idx_width(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [PSW-1:0] prescale,
    input  logic [CW-1:0]  period,
    input  logic           upd_valid,
    output logic           upd_ready,
    input  logic [CHW-1:0] upd_ch,
    input  logic [CW-1:0]  upd_duty,
    output logic [NCH-1:0] pwm_out,
    output logic           period_strobe,
    output logic [CW-1:0]  cnt
);

    logic [PSW-1:0] ps_reg;
    logic [CW-1:0]  cnt_reg;
    logic [CW-1:0]  cnt_next;
    logic           strobe_reg;
    logic           tick;
    logic           wrap;

    // ">=" rather than "==" so a live reduction of prescale below the
    // current prescaler value still produces a tick instead of rolling over.
    assign tick = en && (ps_reg >= prescale);

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_up_reg;
    logic dir_up_next;

    // Up/down counter: flip at the top, wrap when the down-count reaches 0
    always_comb begin
        cnt_next    = cnt_reg;
        dir_up_next = dir_up_reg;
        wrap        = 1'b0;
        if (tick) begin
            if (dir_up_reg && (cnt_reg < period)) begin
                cnt_next = cnt_reg + CW'(1);
            end else if (cnt_reg <= CW'(1)) begin
                // Landing on 0 going down (or period=0): this is the wrap
                cnt_next    = '0;
                dir_up_next = 1'b1;
                wrap        = 1'b1;
            end else begin
                cnt_next    = cnt_reg - CW'(1);
                dir_up_next = 1'b0;
            end
        end
    end
`else
    // Sawtooth counter: wrap to 0 once cnt reaches (or exceeds) period
    always_comb begin
        cnt_next = cnt_reg;
        wrap     = 1'b0;
        if (tick) begin
            if (cnt_reg >= period) begin
                cnt_next = '0;
                wrap     = 1'b1;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end
`endif

    // Prescaler, counter and wrap strobe; stopping clears the timebase
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            ps_reg     <= '0;
            cnt_reg    <= '0;
            strobe_reg <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_reg <= 1'b1;
`endif
        end else begin
            ps_reg     <= tick ? '0 : ps_reg + PSW'(1);
            cnt_reg    <= cnt_next;
            strobe_reg <= wrap;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_reg <= dir_up_next;
`endif
        end
    end

    assign cnt           = cnt_reg;
    assign period_strobe = strobe_reg;

    // Channel array; index slots beyond NCH read as never pending so an
    // out-of-range update is accepted and dropped.
    logic [NCH-1:0]        pend;
    logic [NCH-1:0]        wr_en;
    logic [(1<<CHW)-1:0]   pend_ext;

    genvar gi;
    generate
        for (gi = 0; gi < (1 << CHW); gi++) begin : g_ch
            if (gi < NCH) begin : g_real
                assign pend_ext[gi] = pend[gi];
                assign wr_en[gi]    = upd_valid && upd_ready && (upd_ch == CHW'(gi));

                pwm_channel #(
                    .CW (CW)
                ) u_ch (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (en),
                    .cnt     (cnt_reg),
                    .wrap    (wrap),
                    .wr_en   (wr_en[gi]),
                    .wr_duty (upd_duty),
                    .pend    (pend[gi]),
                    .pwm     (pwm_out[gi])
                );
            end else begin : g_pad
                assign pend_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign upd_ready = !pend_ext[upd_ch];

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: table of configurations with
// expected high/strobe counts, hand sequences for shadow-update, period
// change and reset corners, and randomized configurations checked against
// an arithmetic model of the counter (tick count -> counter value).
module tb_pwm_multi_channel;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int PSW = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [PSW-1:0] prescale;
    logic [CW-1:0]  period;
    logic           upd_valid;
    logic           upd_ready;
    logic [CHW-1:0] upd_ch;
    logic [CW-1:0]  upd_duty;
    logic [NCH-1:0] pwm_out;
    logic           period_strobe;
    logic [CW-1:0]  cnt;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .NCH (NCH),
        .CW  (CW),
        .PSW (PSW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .prescale      (prescale),
        .period        (period),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_ch        (upd_ch),
        .upd_duty      (upd_duty),
        .pwm_out       (pwm_out),
        .period_strobe (period_strobe),
        .cnt           (cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef int d4_t [NCH];

    typedef struct {
        int                   ps;
        int                   per;
        logic [NCH-1:0][15:0] duty;
        int                   cycles;
        logic [NCH-1:0][15:0] highs;
        int                   strobes;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clk; outputs are then read 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; upd_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic write_duty(input int ch, input int d);
        int n;
        upd_ch = CHW'(ch); upd_duty = CW'(d); upd_valid = 1'b1;
        #1;
        n = 0;
        while (!upd_ready && n < 100) begin
            cyc();
            n++;
        end
        check("write_ready", int'(upd_ready), 1);
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (int'(cnt) != v && n < 100) begin
            cyc();
            n++;
        end
        check("wait_cnt", int'(cnt), v);
    endtask

    // Reset, load duties while stopped, then start with the given timebase
    task automatic setup(input int ps, input int per, input d4_t d);
        do_reset();
        for (int c = 0; c < NCH; c++) write_duty(c, d[c]);
        cyc();
        prescale = PSW'(ps);
        period   = CW'(per);
        en       = 1'b1;
    endtask

    task automatic set_vec(input int i, input int ps, input int per,
                           input int d0, input int d1, input int d2, input int d3,
                           input int cy, input int h0, input int h1, input int h2,
                           input int h3, input int s);
        vecs[i].ps = ps; vecs[i].per = per; vecs[i].cycles = cy; vecs[i].strobes = s;
        vecs[i].duty[0] = 16'(d0); vecs[i].duty[1] = 16'(d1);
        vecs[i].duty[2] = 16'(d2); vecs[i].duty[3] = 16'(d3);
        vecs[i].highs[0] = 16'(h0); vecs[i].highs[1] = 16'(h1);
        vecs[i].highs[2] = 16'(h2); vecs[i].highs[3] = 16'(h3);
    endtask

    // Counter value after t ticks from a fresh start
    function automatic int cnt_of(input int t, input int per);
`ifdef PWM_CENTER_ALIGN_EN
        int p;
        if (per == 0) return 0;
        p = t % (2 * per);
        return (p <= per) ? p : 2 * per - p;
`else
        return t % (per + 1);
`endif
    endfunction

    // Does the t-th tick end a full PWM cycle
    function automatic bit wrap_at(input int t, input int per);
        if (t == 0) return 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        return (per == 0) || (t % (2 * per) == 0);
`else
        return (t % (per + 1)) == 0;
`endif
    endfunction

    initial begin
        int hi [NCH];
        int st;
        int bad;
        int ps_r, per_r, pw, ex_cnt, ex_s, ex, ac, pp;
        d4_t dv;

        rst = 1'b1; en = 1'b0; prescale = '0; period = '0;
        upd_valid = 1'b0; upd_ch = '0; upd_duty = '0;
        cyc(); cyc();
        check("reset_cnt", int'(cnt), 0);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_strobe", int'(period_strobe), 0);
        check("reset_ready", int'(upd_ready), 1);
        rst = 1'b0;

        // ---------------- table-driven configurations ----------------
        set_vec(0, 0, 9,   0, 3, 5, 12,     20,  0, 6, 10, 20,  2);
        set_vec(1, 3, 4,   2, 0, 9, 1,      20,  8, 0, 20, 4,   1);
        set_vec(2, 1, 0,   0, 1, 2, 255,    20,  0, 20, 20, 20, 10);
        set_vec(3, 0, 255, 255, 128, 1, 0,  20,  20, 20, 1, 0,  0);
`ifdef PWM_CENTER_ALIGN_EN
        vecs[0].highs[1] = 16'd7; vecs[0].highs[2] = 16'd11; vecs[0].strobes = 1;
        vecs[1].strobes = 0;
`endif
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < NCH; c++) dv[c] = int'(vecs[v].duty[c]);
            setup(vecs[v].ps, vecs[v].per, dv);
            for (int c = 0; c < NCH; c++) hi[c] = 0;
            st = 0;
            for (int j = 0; j < vecs[v].cycles; j++) begin
                cyc();
                for (int c = 0; c < NCH; c++) hi[c] += int'(pwm_out[c]);
                st += int'(period_strobe);
            end
            for (int c = 0; c < NCH; c++)
                check($sformatf("vec%0d_highs_ch%0d", v, c), hi[c], int'(vecs[v].highs[c]));
            check($sformatf("vec%0d_strobes", v), st, vecs[v].strobes);
            en = 1'b0;
            cyc();
            check($sformatf("vec%0d_stop_cnt", v), int'(cnt), 0);
            check($sformatf("vec%0d_stop_pwm", v), int'(pwm_out), 0);
            $display("vector %0d: prescale=%0d period=%0d highs=%0d/%0d/%0d/%0d strobes=%0d",
                     v, vecs[v].ps, vecs[v].per, hi[0], hi[1], hi[2], hi[3], st);
        end

`ifndef PWM_CENTER_ALIGN_EN
        // ---------------- mid-period shadow update ----------------
        setup(0, 9, '{0, 3, 5, 12});
        wait_cnt(4);
        upd_ch = 2'd1; upd_duty = 8'd7; upd_valid = 1'b1;
        #1;
        check("a_ready_first", int'(upd_ready), 1);
        cyc();
        upd_duty = 8'd2;
        #1;
        check("a_stall_ch1", int'(upd_ready), 0);
        upd_ch = 2'd2; upd_duty = 8'd6;
        #1;
        check("a_ready_ch2", int'(upd_ready), 1);
        cyc();
        upd_valid = 1'b0; upd_ch = 2'd1;
        #1;
        hi[1] = int'(pwm_out[1]);
        bad = 0;
        pp = 0;
        while (!period_strobe && pp < 30) begin
            if (upd_ready) bad++;
            cyc();
            hi[1] += int'(pwm_out[1]);
            pp++;
        end
        check("a_strobe_seen", int'(period_strobe), 1);
        check("a_ready_low_while_pending", bad, 0);
        check("a_old_duty_highs", hi[1], 0);
        check("a_ready_after_wrap", int'(upd_ready), 1);
        hi[1] = 0; hi[2] = 0;
        for (int j = 0; j < 10; j++) begin
            cyc();
            hi[1] += int'(pwm_out[1]);
            hi[2] += int'(pwm_out[2]);
        end
        check("a_new_duty_ch1", hi[1], 7);
        check("a_new_duty_ch2", hi[2], 6);
        $display("shadow update: ch1 new highs=%0d ch2 new highs=%0d", hi[1], hi[2]);

        // ---------------- live period reduction ----------------
        setup(0, 15, '{0, 0, 0, 0});
        wait_cnt(10);
        period = 8'd5;
        cyc();
        check("b_wrap_cnt", int'(cnt), 0);
        check("b_wrap_strobe", int'(period_strobe), 1);
        st = 0;
        for (int j = 0; j < 6; j++) begin
            cyc();
            st += int'(period_strobe);
        end
        check("b_strobes_after", st, 1);
        check("b_cnt_after", int'(cnt), 0);
        $display("period reduce: strobes in next period=%0d", st);
`else
        // ---------------- centre-aligned sequence ----------------
        setup(0, 4, '{2, 2, 2, 2});
        begin
            int seq [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
            hi[0] = 0; st = 0;
            for (int j = 0; j < 16; j++) begin
                cyc();
                check($sformatf("d_cnt_%0d", j), int'(cnt), seq[j % 8]);
                check($sformatf("d_strobe_%0d", j), int'(period_strobe), (j % 8 == 7) ? 1 : 0);
                hi[0] += int'(pwm_out[0]);
            end
            check("d_highs", hi[0], 6);
            $display("centre aligned: highs=%0d over 16 cycles", hi[0]);
        end
`endif

        // ---------------- reset with a pending update ----------------
        setup(0, 9, '{0, 3, 5, 12});
        wait_cnt(7);
        write_duty(0, 9);
        rst = 1'b1;
        upd_ch = 2'd0;
        cyc();
        check("c_rst_cnt", int'(cnt), 0);
        check("c_rst_pwm", int'(pwm_out), 0);
        check("c_rst_strobe", int'(period_strobe), 0);
        check("c_rst_ready", int'(upd_ready), 1);
        rst = 1'b0;
        bad = 0;
        for (int j = 0; j < 25; j++) begin
            cyc();
            if (pwm_out != '0) bad++;
        end
        check("c_pending_discarded", bad, 0);
        $display("reset with pending: cycles with output high=%0d", bad);

        // ---------------- randomized configurations ----------------
        for (int tr = 0; tr < 6; tr++) begin
            ps_r  = int'($urandom_range(0, 3));
            per_r = int'($urandom_range(0, 12));
            for (int c = 0; c < NCH; c++) dv[c] = int'($urandom_range(0, 15));
            setup(ps_r, per_r, dv);
            bad = 0;
            for (int j = 0; j < 40; j++) begin
                cyc();
                pp     = ps_r + 1;
                ex_cnt = cnt_of((j + 1) / pp, per_r);
                ex_s   = (((j + 1) % pp == 0) && wrap_at((j + 1) / pp, per_r)) ? 1 : 0;
                pw     = 0;
                for (int c = 0; c < NCH; c++)
                    if (cnt_of(j / pp, per_r) < dv[c]) pw |= (1 << c);
                ex = (ex_s << 12) | (pw << 8) | ex_cnt;
                ac = int'({period_strobe, pwm_out, cnt});
                if (ac != ex) bad++;
                check($sformatf("rand%0d_cyc%0d_strobe_pwm_cnt", tr, j), ac, ex);
            end
            en = 1'b0;
            $display("random %0d: prescale=%0d period=%0d duty=%0d/%0d/%0d/%0d deviations=%0d",
                     tr, ps_r, per_r, dv[0], dv[1], dv[2], dv[3], bad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
